// File: rtl/tt_um_serial_rx.sv
// 8N1 LSB-first serial receiver on the standard tile pinout.
// The received byte is held on uo_out; valid/frame_err/overrun/busy are reported on uio_out[3:0].
module tt_um_serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 104
) (
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe,
   input  logic       ena,
   input  logic       clk,
   input  logic       rst_n
);

   localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CntW-1:0] HalfM1 = CntW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CntW-1:0] FullM1 = CntW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

   state_e          state_q, state_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [2:0]      idx_q, idx_d;
   logic [7:0]      shift_q, shift_d;
   logic [7:0]      hold_q, hold_d;
   logic            valid_q, valid_d;
   logic            ferr_q, ferr_d;
   logic            ovr_q, ovr_d;
   logic            busy_q, busy_d;

   logic rx_s1_q, rx_s2_q, rx_prev_q;
   logic ack_s1_q, ack_s2_q, ack_prev_q;
   logic rx_fall, ack_rise;

   assign rx_fall  = rx_prev_q & ~rx_s2_q;
   assign ack_rise = ack_s2_q & ~ack_prev_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = idx_q;
      shift_d = shift_q;
      hold_d  = hold_q;
      valid_d = valid_q;
      ferr_d  = ferr_q;
      ovr_d   = ovr_q;

      if (ack_rise) begin
         valid_d = 1'b0;
         ferr_d  = 1'b0;
         ovr_d   = 1'b0;
      end

      if (!ena) begin
         state_d = StIdle;
         cnt_d   = '0;
         idx_d   = '0;
      end else begin
         case (state_q)
            StIdle: begin
               if (rx_fall) begin
                  state_d = StStart;
                  cnt_d   = '0;
               end
            end
            StStart: begin
               if (cnt_q == HalfM1) begin
                  cnt_d   = '0;
                  idx_d   = '0;
                  state_d = rx_s2_q ? StIdle : StData;
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StData: begin
               if (cnt_q == FullM1) begin
                  cnt_d          = '0;
                  shift_d[idx_q] = rx_s2_q;
                  if (idx_q == 3'd7) begin
                     state_d = StStop;
                  end else begin
                     idx_d = idx_q + 3'd1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            StStop: begin
               if (cnt_q == FullM1) begin
                  cnt_d   = '0;
                  state_d = StIdle;
                  if (rx_s2_q) begin
                     // Capture takes priority over a coincident ack edge.
                     hold_d  = shift_q;
                     valid_d = 1'b1;
                     ferr_d  = 1'b0;
                     if (valid_q && !ack_rise) begin
                        ovr_d = 1'b1;
                     end
                  end else begin
                     ferr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + CntW'(1);
               end
            end
            default: state_d = StIdle;
         endcase
      end

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_s1_q    <= 1'b1;
         rx_s2_q    <= 1'b1;
         rx_prev_q  <= 1'b1;
         ack_s1_q   <= 1'b0;
         ack_s2_q   <= 1'b0;
         ack_prev_q <= 1'b0;
         state_q    <= StIdle;
         cnt_q      <= '0;
         idx_q      <= '0;
         shift_q    <= '0;
         hold_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         ovr_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         rx_s1_q    <= ui_in[0];
         rx_s2_q    <= rx_s1_q;
         rx_prev_q  <= rx_s2_q;
         ack_s1_q   <= ui_in[1];
         ack_s2_q   <= ack_s1_q;
         ack_prev_q <= ack_s2_q;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         idx_q      <= idx_d;
         shift_q    <= shift_d;
         hold_q     <= hold_d;
         valid_q    <= valid_d;
         ferr_q     <= ferr_d;
         ovr_q      <= ovr_d;
         busy_q     <= busy_d;
      end
   end

   assign uo_out  = hold_q ^ {8{ui_in[2]}};
   assign uio_out = {4'b0000, busy_q, ovr_q, ferr_q, valid_q};
   assign uio_oe  = 8'b0000_1111;

   logic unused_ok;
   assign unused_ok = ^{uio_in, ui_in[7:3]};

endmodule

// File: tb/tb_tt_um_serial_rx.sv
// Randomized scoreboard bench for tt_um_serial_rx at 16 clocks per bit.
// Every busy 1->0 transition is matched against an expected outcome queued by the driver.
module tb_tt_um_serial_rx;

   localparam int CPB = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       ena = 1'b1;
   logic       rx = 1'b1, ack = 1'b0, inv = 1'b0;
   logic [4:0] junk = '0;
   logic [7:0] uio_in = '0;
   logic [7:0] ui_in, uo_out, uio_out, uio_oe;

   assign ui_in = {junk, inv, ack, rx};

   tt_um_serial_rx #(.CLKS_PER_BIT(CPB)) dut (
      .ui_in  (ui_in),
      .uo_out (uo_out),
      .uio_in (uio_in),
      .uio_out(uio_out),
      .uio_oe (uio_oe),
      .ena    (ena),
      .clk    (clk),
      .rst_n  (rst_n)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Reference model: the receiver's visible state in plain terms.
   logic [7:0] m_hold = 8'h00;
   bit         m_valid = 0, m_ferr = 0, m_ovr = 0;

   function automatic logic [2:0] m_flags();
      return {m_ovr, m_ferr, m_valid};
   endfunction

   function automatic void model_frame(input logic [7:0] d, input bit stop_ok);
      if (stop_ok) begin
         m_ovr   = m_ovr | m_valid;
         m_hold  = d;
         m_valid = 1;
         m_ferr  = 0;
      end else begin
         m_ferr = 1;
      end
   endfunction

   function automatic void model_clear();
      m_valid = 0;
      m_ferr  = 0;
      m_ovr   = 0;
   endfunction

   typedef struct {
      logic [7:0] uo;
      logic [7:0] uio;
      int         cyc;
      string      name;
   } exp_t;

   exp_t exp_q[$];

   task automatic push_exp(input string name, input int at_cyc);
      exp_t e;
      e.uo   = m_hold ^ {8{inv}};
      e.uio  = {5'b0, m_flags()};
      e.cyc  = at_cyc;
      e.name = name;
      exp_q.push_back(e);
   endtask

   // Monitor: each end of activity (busy falling) must match the next queued outcome.
   initial begin : monitor
      logic busy_prev;
      exp_t e;
      busy_prev = 1'b0;
      forever begin
         @(negedge clk);
         if (busy_prev && !uio_out[3]) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_end_of_frame", 32'(uio_out), 32'hFFFF_FFFF);
            end else begin
               e = exp_q.pop_front();
               chk({e.name, "_uo_out"}, 32'(uo_out), 32'(e.uo));
               chk({e.name, "_uio_out"}, 32'(uio_out), 32'(e.uio));
               if (e.cyc >= 0) chk({e.name, "_latency"}, 32'(cyc), 32'(e.cyc));
            end
         end
         busy_prev = uio_out[3];
      end
   end

   // Inputs change 1 time unit after the falling edge, after the monitor has sampled.
   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (CPB) tick();
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_ok, input string name);
      int c0;
      c0 = cyc;
      model_frame(d, stop_ok);
      // Pin edge -> 3 cycles to detect, half bit to start sample, 9 bits to stop sample.
      push_exp(name, c0 + 3 + CPB / 2 + 9 * CPB);
      drive_bit(1'b0);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
      drive_bit(stop_ok);
   endtask

   task automatic pulse_ack(input string name);
      ack = 1'b1;
      tick();
      tick();
      chk({name, "_flags_before"}, 32'(uio_out[2:0]), 32'(m_flags()));
      tick();
      model_clear();
      chk({name, "_flags_cleared"}, 32'(uio_out[2:0]), 32'(m_flags()));
      ack = 1'b0;
      repeat (4) tick();
   endtask

   initial begin : driver
      bit         line_low;
      bit         stop_ok;
      logic [7:0] d;
      int         sel;

      // Reset values
      rst_n = 1'b0;
      repeat (3) tick();
      chk("reset_uo_out", 32'(uo_out), 32'h00);
      chk("reset_uio_out", 32'(uio_out), 32'h00);
      chk("reset_uio_oe", 32'(uio_oe), 32'h0F);
      inv = 1'b1;
      #1;
      chk("reset_uo_out_inv", 32'(uo_out), 32'hFF);
      inv = 1'b0;
      rst_n = 1'b1;
      repeat (4) tick();

      // Basic receive, invert, ack
      send_frame(8'hA5, 1'b1, "basic_A5");
      inv = 1'b1;
      #1;
      chk("inv_uo_out", 32'(uo_out), 32'h5A);
      inv = 1'b0;
      pulse_ack("ack1");

      // Overrun: two frames back to back without ack
      send_frame(8'h3C, 1'b1, "ovr_3C");
      send_frame(8'hC3, 1'b1, "ovr_C3");
      chk("ovr_flag", 32'(uio_out[2]), 32'h1);
      pulse_ack("ack_ovr");
      drive_bit(1'b1);

      // Framing error, then line held low (break)
      send_frame(8'h12, 1'b1, "pre_ferr_12");
      send_frame(8'h55, 1'b0, "ferr_55");
      repeat (3 * CPB) tick();
      chk("break_no_busy", 32'(uio_out[3]), 32'h0);
      chk("break_uo_out", 32'(uo_out), 32'h12);
      drive_bit(1'b1);

      // Glitch: short low pulse is rejected at the start sample
      push_exp("glitch", cyc + 3 + CPB / 2);
      rx = 1'b0;
      repeat (4) tick();
      rx = 1'b1;
      repeat (2 * CPB) tick();
      pulse_ack("ack_glitch");

      // ena dropped during data bit 3
      d = 8'hE7;
      drive_bit(1'b0);
      for (int i = 0; i < 3; i++) drive_bit(d[i]);
      rx = d[3];
      repeat (CPB / 2) tick();
      ena = 1'b0;
      push_exp("ena_abort", cyc + 1);
      tick();
      rx = 1'b1;
      repeat (10 * CPB) tick();
      ena = 1'b1;
      repeat (2) tick();
      chk("ena_abort_busy", 32'(uio_out[3]), 32'h0);
      chk("ena_abort_valid", 32'(uio_out[0]), 32'h0);

      // Asynchronous reset mid-frame, after a byte has been captured
      send_frame(8'h6B, 1'b1, "pre_rst_6B");
      d = 8'h9E;
      drive_bit(1'b0);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      m_hold = 8'h00;
      model_clear();
      push_exp("reset_abort", -1);
      rst_n = 1'b0;
      #1;
      chk("rst_mid_uo_out", 32'(uo_out), 32'h00);
      chk("rst_mid_uio_out", 32'(uio_out), 32'h00);
      chk("rst_mid_uio_oe", 32'(uio_oe), 32'h0F);
      rx = 1'b1;
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (CPB) tick();
      send_frame(8'h81, 1'b1, "after_rst_81");
      drive_bit(1'b1);

      // Randomized frames with random data, stop errors, acks, gaps and inversion
      line_low = 1'b0;
      for (int n = 0; n < 14; n++) begin
         if (line_low) drive_bit(1'b1);
         inv     = 1'($urandom_range(0, 1));
         junk    = 5'($urandom);
         uio_in  = 8'($urandom);
         d       = 8'($urandom);
         stop_ok = ($urandom_range(0, 4) != 0);
         send_frame(d, stop_ok, $sformatf("rand%0d", n));
         line_low = !stop_ok;
         sel = int'($urandom_range(0, 3));
         if (sel == 0) begin
            pulse_ack($sformatf("rand_ack%0d", n));
         end else if (sel == 1) begin
            rx = 1'b1;
            line_low = 1'b0;
            repeat ($urandom_range(2, 3 * CPB)) tick();
         end
      end

      // Drain: all queued outcomes must have been observed
      rx = 1'b1;
      for (int i = 0; i < 4 * CPB && exp_q.size() != 0; i++) tick();
      chk("queue_drained", 32'(exp_q.size()), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
